// File: rtl/avalon_mms_ram_slave.sv
// Avalon-MM RAM slave that emulates an SDRAM controller: init stall, fixed read latency, bounded outstanding reads.
// Optional periodic refresh stall is enabled by defining REFRESH_STALL_EN.
module avalon_mms_ram_slave #(
    parameter int P_DATA_NBIT = 32,
    parameter int P_ADDR_NBIT = 26,
    parameter int P_MEM_ABITS = 8,
    parameter int P_RD_LAT    = 3,
    parameter int P_MAX_PEND  = 2,
    parameter int P_INIT_CYC  = 16
`ifdef REFRESH_STALL_EN
    ,
    parameter int P_REF_PERIOD = 64,
    parameter int P_REF_CYC    = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [P_ADDR_NBIT-1:0]   avalon_mms_address,
    input  logic [P_DATA_NBIT/8-1:0] avalon_mms_byteenable_n,
    input  logic                     avalon_mms_chipselect,
    input  logic [P_DATA_NBIT-1:0]   avalon_mms_writedata,
    input  logic                     avalon_mms_read_n,
    input  logic                     avalon_mms_write_n,
    output logic [P_DATA_NBIT-1:0]   avalon_mms_readdata,
    output logic                     avalon_mms_readdatavalid,
    output logic                     avalon_mms_waitrequest
);

    localparam int NBE    = P_DATA_NBIT / 8;
    localparam int PEND_W = $clog2(P_MAX_PEND + 1);
`ifdef REFRESH_STALL_EN
    localparam int CNT_MAX_A = (P_INIT_CYC > P_REF_PERIOD) ? P_INIT_CYC : P_REF_PERIOD;
    localparam int CNT_MAX   = (CNT_MAX_A > P_REF_CYC) ? CNT_MAX_A : P_REF_CYC;
`else
    localparam int CNT_MAX   = P_INIT_CYC;
`endif
    localparam int CNT_W  = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_READY
`ifdef REFRESH_STALL_EN
        ,
        ST_REFRESH
`endif
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [PEND_W-1:0]        pend;
    logic                     wr_acc, rd_acc, ret;
    logic [P_MEM_ABITS-1:0]   widx;
    logic                     unused_addr_hi;

    logic [P_DATA_NBIT-1:0]   mem [2**P_MEM_ABITS];
    logic [P_RD_LAT-1:0]      vld, in_vld;
    logic [P_DATA_NBIT-1:0]   dat    [P_RD_LAT];
    logic [P_DATA_NBIT-1:0]   in_dat [P_RD_LAT];

    assign widx           = avalon_mms_address[P_MEM_ABITS-1:0];
    assign unused_addr_hi = ^avalon_mms_address[P_ADDR_NBIT-1:P_MEM_ABITS];

    // One counter serves the init phase and, when enabled, the refresh period and stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                if (cnt == CNT_W'(P_INIT_CYC - 1)) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_READY: begin
`ifdef REFRESH_STALL_EN
                if (cnt == CNT_W'(P_REF_PERIOD - 1)) begin
                    state_nxt = ST_REFRESH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
`ifdef REFRESH_STALL_EN
            ST_REFRESH: begin
                if (cnt == CNT_W'(P_REF_CYC - 1)) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        avalon_mms_waitrequest = (state != ST_READY) || (pend == PEND_W'(P_MAX_PEND));
    end

    assign wr_acc = avalon_mms_chipselect & ~avalon_mms_write_n & ~avalon_mms_waitrequest;
    assign rd_acc = avalon_mms_chipselect & ~avalon_mms_read_n & avalon_mms_write_n
                    & ~avalon_mms_waitrequest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Array is deliberately not reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < NBE; i++) begin
                if (!avalon_mms_byteenable_n[i]) begin
                    mem[widx][8*i +: 8] <= avalon_mms_writedata[8*i +: 8];
                end
            end
        end
    end

    // Last pipeline stage is the output register; its input valid marks a read completing.
    always_comb begin
        in_vld[0] = rd_acc;
        in_dat[0] = mem[widx];
        for (int unsigned k = 1; k < P_RD_LAT; k++) begin
            in_vld[k] = vld[k-1];
            in_dat[k] = dat[k-1];
        end
    end

    assign ret = in_vld[P_RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned k = 0; k < P_RD_LAT; k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld <= in_vld;
            for (int unsigned k = 0; k < P_RD_LAT; k++) begin
                if (in_vld[k]) begin
                    dat[k] <= in_dat[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            case ({rd_acc, ret})
                2'b10:   pend <= pend + PEND_W'(1);
                2'b01:   pend <= pend - PEND_W'(1);
                default: pend <= pend;
            endcase
        end
    end

    assign avalon_mms_readdatavalid = vld[P_RD_LAT-1];
    assign avalon_mms_readdata      = dat[P_RD_LAT-1];

endmodule
